// File: rtl/mcs4_pkg.sv
// Shared MCS-4 types: instruction-cycle phases, ROM address layout and byte type.
package mcs4;

  typedef enum logic [3:0] {
    CYC_A1, CYC_A2, CYC_A3, CYC_M1, CYC_M2, CYC_X1, CYC_X2, CYC_X3, CYC_UNSYNC
  } instr_cyc_t;

  localparam int Rom_page_bytes = 256;
  localparam int Rom_chip_w     = 4;

  typedef struct packed {
    logic [Rom_chip_w-1:0] chip;
    logic [3:0]            mid;
    logic [3:0]            lo;
  } rom_addr_t;

  typedef logic [7:0] rom_byte_t;

  // X3 wraps back to A1; only called while the tracker is locked.
  function automatic instr_cyc_t next_cyc(instr_cyc_t c);
    return (c == CYC_X3) ? CYC_A1 : instr_cyc_t'(4'(c) + 4'd1);
  endfunction

endpackage

// File: rtl/mcs4_rom_ctrl_if.sv
// CPU data-bus and host loader signals of the ROM controller.
interface mcs4_rom_ctrl_if #(
  parameter int ADDR_W = 12
) ();

  logic              sync;
  logic              cm_rom;
  logic [3:0]        dbus_in;
  logic [3:0]        dbus_out;
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [7:0]        host_wdata;
  logic              host_ack;
  logic [7:0]        host_rdata;
  logic              locked;
  logic              sync_err;

  modport master (
    output sync, cm_rom, dbus_in, host_req, host_we, host_addr, host_wdata,
    input  dbus_out, host_ack, host_rdata, locked, sync_err
  );

  modport slave (
    input  sync, cm_rom, dbus_in, host_req, host_we, host_addr, host_wdata,
    output dbus_out, host_ack, host_rdata, locked, sync_err
  );

endinterface

// File: rtl/mcs4_rom_ram.sv
// Single-port byte RAM with registered read, shaped to map onto block RAM.
module mcs4_rom_ram
  import mcs4::*;
#(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  rom_byte_t     wdata,
  output rom_byte_t     rdata
);

  rom_byte_t mem [DEPTH];

  // Writes leave rdata untouched so a fetched byte survives a host write.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/mcs4_rom_ctrl.sv
// MCS-4 program-memory controller: phase tracker, fetch path and host arbiter
// sharing one RAM port, with the CPU fetch owning the port in A3.
module mcs4_rom_ctrl
  import mcs4::*;
#(
  parameter int NUM_CHIPS = 16,
  parameter int ADDR_W    = 12
) (
  input logic            clk,
  input logic            rst,
  mcs4_rom_ctrl_if.slave bus
);

  localparam int Depth = NUM_CHIPS * Rom_page_bytes;
  localparam int RamAw = $clog2(Depth);
  localparam logic [Rom_chip_w:0] ChipLimit = (Rom_chip_w + 1)'(NUM_CHIPS);

  instr_cyc_t phase;
  logic       locked_q, sync_err_q, sel;
  logic [3:0] addr_lo, addr_mid, fetch_lo;
  logic       ack_q, ack_rd_q, ack_oob_q;
  rom_byte_t  rdata_hold, ram_rdata;
  rom_addr_t  host_a, ram_addr;
  logic       chip_ok, host_ok, cpu_owns, cpu_rd, host_grant, ram_en, ram_we;

  assign host_a = rom_addr_t'(bus.host_addr[ADDR_W-1:0]);

  always_comb begin
    chip_ok    = {1'b0, bus.dbus_in} < ChipLimit;
    host_ok    = {1'b0, host_a.chip} < ChipLimit;
    cpu_owns   = (phase == CYC_A3);
    cpu_rd     = cpu_owns && bus.cm_rom && chip_ok;
    host_grant = bus.host_req && !cpu_owns && !ack_q && !rst;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = host_a;
    if (cpu_rd) begin
      ram_en   = 1'b1;
      ram_addr = '{chip: bus.dbus_in, mid: addr_mid, lo: addr_lo};
    end else if (host_grant && host_ok) begin
      ram_en = 1'b1;
      ram_we = bus.host_we;
    end
  end

  mcs4_rom_ram #(.DEPTH(Depth), .AW(RamAw)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr[RamAw-1:0]),
    .wdata (bus.host_wdata),
    .rdata (ram_rdata)
  );

  // A stray sync re-aligns to A1; a missing sync in X3 drops lock entirely.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase      <= CYC_UNSYNC;
      locked_q   <= 1'b0;
      sync_err_q <= 1'b0;
      sel        <= 1'b0;
      addr_lo    <= 4'h0;
      addr_mid   <= 4'h0;
      fetch_lo   <= 4'h0;
      ack_q      <= 1'b0;
      ack_rd_q   <= 1'b0;
      ack_oob_q  <= 1'b0;
      rdata_hold <= 8'h00;
    end else begin
      sync_err_q <= 1'b0;
      if (phase == CYC_UNSYNC) begin
        if (bus.sync) begin
          phase    <= CYC_A1;
          locked_q <= 1'b1;
        end
      end else if (phase == CYC_X3) begin
        if (bus.sync) begin
          phase <= CYC_A1;
        end else begin
          phase      <= CYC_UNSYNC;
          locked_q   <= 1'b0;
          sync_err_q <= 1'b1;
        end
      end else if (bus.sync) begin
        phase      <= CYC_A1;
        sync_err_q <= 1'b1;
      end else begin
        phase <= next_cyc(phase);
      end

      case (phase)
        CYC_A1:  addr_lo  <= bus.dbus_in;
        CYC_A2:  addr_mid <= bus.dbus_in;
        CYC_A3:  sel      <= bus.cm_rom && chip_ok;
        CYC_M1:  fetch_lo <= ram_rdata[3:0];
        CYC_X1:  sel      <= 1'b0;
        default: ;
      endcase

      ack_q     <= host_grant;
      ack_rd_q  <= host_grant && !bus.host_we;
      ack_oob_q <= host_grant && !host_ok;
      if (ack_rd_q) rdata_hold <= ack_oob_q ? 8'h00 : ram_rdata;
    end
  end

  // M1 reads the RAM output directly; M2 uses the nibble saved at the end of M1.
  always_comb begin
    bus.dbus_out = 4'h0;
    if (sel && phase == CYC_M1) bus.dbus_out = ram_rdata[7:4];
    if (sel && phase == CYC_M2) bus.dbus_out = fetch_lo;
  end

  assign bus.host_ack   = ack_q;
  assign bus.host_rdata = ack_rd_q ? (ack_oob_q ? 8'h00 : ram_rdata) : rdata_hold;
  assign bus.locked     = locked_q;
  assign bus.sync_err   = sync_err_q;

endmodule

// File: tb/tb_mcs4_rom_ctrl.sv
// Self-checking bench for mcs4_rom_ctrl with two ROM chips, so chip nibbles 2..15 are out of range.
module tb_mcs4_rom_ctrl;
  import mcs4::*;

  localparam int NChips = 2;
  localparam int Depth  = NChips * 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mcs4_rom_ctrl_if #(.ADDR_W(12)) bus ();

  mcs4_rom_ctrl #(.NUM_CHIPS(NChips), .ADDR_W(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] model [Depth];
  logic [3:0] f_dout [8];
  logic       f_err  [8];
  logic       f_lk   [8];

  // One bus cycle: sample what the DUT shows in this phase, then drive the CPU lines.
  task automatic cpu_cycle(input logic s, input logic cm, input logic [3:0] d,
                           output logic [3:0] dout, output logic er, output logic lk);
    @(negedge clk);
    dout = bus.dbus_out;
    er   = bus.sync_err;
    lk   = bus.locked;
    bus.sync    = s;
    bus.cm_rom  = cm;
    bus.dbus_in = d;
  endtask

  // Eight CPU cycles A1..X3 fetching address a; sync is driven only in cycle sync_at (1..8).
  task automatic run_fetch(input logic [11:0] a, input logic cm, input int sync_at);
    for (int i = 0; i < 8; i++) begin
      logic [3:0] d;
      d = (i == 0) ? a[3:0] : (i == 1) ? a[7:4] : (i == 2) ? a[11:8] : 4'h0;
      cpu_cycle((i + 1) == sync_at, (i == 2) && cm, d, f_dout[i], f_err[i], f_lk[i]);
    end
  endtask

  // Host access raised at the start-th negedge; lat counts request cycle through ack cycle.
  task automatic host_access(input int start, input logic we, input logic [11:0] a,
                             input logic [7:0] wd, output int lat, output logic [7:0] rd);
    repeat (start) @(negedge clk);
    bus.host_req   = 1'b1;
    bus.host_we    = we;
    bus.host_addr  = a;
    bus.host_wdata = wd;
    lat = 1;
    rd  = 8'h00;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus.host_ack) begin
        rd = bus.host_rdata;
        break;
      end
    end
    bus.host_req = 1'b0;
  endtask

  function automatic logic [3:0] exp_nib(input int i, input logic [7:0] b, input logic on);
    if (on && i == 3) return b[7:4];
    if (on && i == 4) return b[3:0];
    return 4'h0;
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (bus.dbus_out !== 4'h0) begin errors++; $display("[TB] FAIL reset_dbus_out got=%h exp=0", bus.dbus_out); end
    checks++; if (bus.host_ack !== 1'b0) begin errors++; $display("[TB] FAIL reset_host_ack got=%b exp=0", bus.host_ack); end
    checks++; if (bus.host_rdata !== 8'h00) begin errors++; $display("[TB] FAIL reset_host_rdata got=%h exp=00", bus.host_rdata); end
    checks++; if (bus.locked !== 1'b0) begin errors++; $display("[TB] FAIL reset_locked got=%b exp=0", bus.locked); end
    checks++; if (bus.sync_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_sync_err got=%b exp=0", bus.sync_err); end
    rst = 1'b0;
  endtask

  task automatic test_preload();
    int lat;
    logic [7:0] rd, wd;
    logic [11:0] a;
    for (int i = 0; i < Depth + 2; i++) begin
      a  = (i == Depth) ? 12'h123 : (i == Depth + 1) ? 12'h045 : 12'(i);
      wd = (i == Depth) ? 8'hA5 : (i == Depth + 1) ? 8'h77 : 8'($urandom);
      host_access(1, 1'b1, a, wd, lat, rd);
      model[a[8:0]] = wd;
      checks++; if (lat != 2) begin errors++; $display("[TB] FAIL preload_latency addr=%h got=%0d exp=2", a, lat); end
    end
    for (int i = 0; i < 16; i++) begin
      a = 12'($urandom_range(0, Depth - 1));
      host_access(1, 1'b0, a, 8'h00, lat, rd);
      checks++; if (rd !== model[a[8:0]]) begin errors++; $display("[TB] FAIL unsync_read addr=%h got=%h exp=%h", a, rd, model[a[8:0]]); end
    end
  endtask

  task automatic test_lock();
    logic [3:0] d;
    logic er, lk;
    cpu_cycle(1'b1, 1'b0, 4'h0, d, er, lk);
    checks++; if (lk !== 1'b0) begin errors++; $display("[TB] FAIL prelock_locked got=%b exp=0", lk); end
  endtask

  task automatic test_fetch_basic();
    int lat;
    logic [7:0] rd;
    fork
      run_fetch(12'h123, 1'b1, 8);
      host_access(1, 1'b0, 12'h045, 8'h00, lat, rd);
    join
    checks++; if (f_lk[0] !== 1'b1 || f_err[0] !== 1'b0) begin errors++; $display("[TB] FAIL lock_after_sync locked=%b err=%b exp locked=1 err=0", f_lk[0], f_err[0]); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (f_dout[i] !== exp_nib(i, 8'hA5, 1'b1)) begin errors++; $display("[TB] FAIL fetch_123 phase=%0d got=%h exp=%h", i, f_dout[i], exp_nib(i, 8'hA5, 1'b1)); end
    end
    checks++; if (bus.host_rdata !== 8'h77) begin errors++; $display("[TB] FAIL rdata_hold got=%h exp=77", bus.host_rdata); end
  endtask

  task automatic test_cm_rom_off();
    int lat;
    logic [7:0] rd;
    fork
      run_fetch(12'h123, 1'b0, 8);
      host_access(1, 1'b0, 12'h123, 8'h00, lat, rd);
    join
    for (int i = 0; i < 8; i++) begin
      checks++; if (f_dout[i] !== 4'h0) begin errors++; $display("[TB] FAIL cm_rom_off phase=%0d got=%h exp=0", i, f_dout[i]); end
    end
    checks++; if (rd !== 8'hA5) begin errors++; $display("[TB] FAIL cm_off_host_read got=%h exp=a5", rd); end
  endtask

  task automatic test_hazard();
    int lat;
    logic [7:0] rd;
    fork
      run_fetch(12'h045, 1'b1, 8);
      host_access(3, 1'b1, 12'h045, 8'h3C, lat, rd);
    join
    model[9'h045] = 8'h3C;
    checks++; if (f_dout[3] !== 4'h7 || f_dout[4] !== 4'h7) begin errors++; $display("[TB] FAIL hazard_old_byte got=%h%h exp=77", f_dout[3], f_dout[4]); end
    checks++; if (lat != 3) begin errors++; $display("[TB] FAIL hazard_latency got=%0d exp=3", lat); end
    run_fetch(12'h045, 1'b1, 8);
    checks++; if (f_dout[3] !== 4'h3 || f_dout[4] !== 4'hC) begin errors++; $display("[TB] FAIL hazard_new_byte got=%h%h exp=3c", f_dout[3], f_dout[4]); end
  endtask

  task automatic test_random_traffic();
    for (int n = 0; n < 24; n++) begin
      logic [11:0] fa, ha;
      logic [7:0]  wd, rd, fb, exp_rd;
      logic        we;
      int          start, lat, grant, exp_lat;
      fa      = 12'($urandom_range(0, Depth - 1));
      ha      = ($urandom_range(0, 1) == 1) ? fa : 12'($urandom_range(0, Depth - 1));
      start   = $urandom_range(1, 7);
      we      = 1'($urandom_range(0, 1));
      wd      = 8'($urandom);
      grant   = (start == 3) ? 4 : start;
      exp_lat = (start == 3) ? 3 : 2;
      fb      = (we && ha == fa && grant < 3) ? wd : model[fa[8:0]];
      exp_rd  = model[ha[8:0]];
      fork
        run_fetch(fa, 1'b1, 8);
        host_access(start, we, ha, wd, lat, rd);
      join
      if (we) model[ha[8:0]] = wd;
      for (int i = 0; i < 8; i++) begin
        checks++; if (f_dout[i] !== exp_nib(i, fb, 1'b1)) begin errors++; $display("[TB] FAIL rand_fetch addr=%h phase=%0d got=%h exp=%h", fa, i, f_dout[i], exp_nib(i, fb, 1'b1)); end
      end
      checks++; if (lat != exp_lat) begin errors++; $display("[TB] FAIL rand_latency start=%0d got=%0d exp=%0d", start, lat, exp_lat); end
      if (!we) begin
        checks++; if (rd !== exp_rd) begin errors++; $display("[TB] FAIL rand_host_read addr=%h got=%h exp=%h", ha, rd, exp_rd); end
      end
    end
  endtask

  task automatic test_out_of_range();
    int lat;
    logic [7:0] rd;
    fork
      run_fetch(12'h300, 1'b1, 8);
      host_access(1, 1'b1, 12'h300, 8'h5A, lat, rd);
    join
    for (int i = 0; i < 8; i++) begin
      checks++; if (f_dout[i] !== 4'h0) begin errors++; $display("[TB] FAIL oob_fetch_300 phase=%0d got=%h exp=0", i, f_dout[i]); end
    end
    checks++; if (lat != 2) begin errors++; $display("[TB] FAIL oob_write_ack got_latency=%0d exp=2", lat); end
    fork
      run_fetch(12'h2AB, 1'b1, 8);
      host_access(2, 1'b0, 12'h300, 8'h00, lat, rd);
    join
    checks++; if (f_dout[3] !== 4'h0 || f_dout[4] !== 4'h0) begin errors++; $display("[TB] FAIL oob_fetch_2ab got=%h%h exp=00", f_dout[3], f_dout[4]); end
    checks++; if (rd !== 8'h00 || lat != 2) begin errors++; $display("[TB] FAIL oob_read got=%h lat=%0d exp=00 lat=2", rd, lat); end
    run_fetch(12'h100, 1'b1, 8);
    checks++; if ({f_dout[3], f_dout[4]} !== model[9'h100]) begin errors++; $display("[TB] FAIL oob_no_alias got=%h%h exp=%h", f_dout[3], f_dout[4], model[9'h100]); end
  endtask

  task automatic test_sync_loss();
    logic [3:0] d;
    logic er, lk;
    run_fetch(12'h123, 1'b1, 0);
    checks++; if (f_dout[3] !== 4'hA || f_dout[4] !== 4'h5) begin errors++; $display("[TB] FAIL last_locked_fetch got=%h%h exp=a5", f_dout[3], f_dout[4]); end
    run_fetch(12'h123, 1'b1, 0);
    checks++; if (f_err[0] !== 1'b1 || f_lk[0] !== 1'b0) begin errors++; $display("[TB] FAIL missing_sync err=%b locked=%b exp err=1 locked=0", f_err[0], f_lk[0]); end
    checks++; if (f_err[1] !== 1'b0) begin errors++; $display("[TB] FAIL sync_err_pulse_width got=%b exp=0", f_err[1]); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (f_dout[i] !== 4'h0 || f_lk[i] !== 1'b0) begin errors++; $display("[TB] FAIL unsync_quiet phase=%0d dout=%h locked=%b exp 0/0", i, f_dout[i], f_lk[i]); end
    end
    cpu_cycle(1'b1, 1'b0, 4'h0, d, er, lk);
    run_fetch(12'h045, 1'b1, 8);
    checks++; if (f_lk[0] !== 1'b1 || f_dout[3] !== 4'h3 || f_dout[4] !== 4'hC) begin errors++; $display("[TB] FAIL relock_fetch locked=%b got=%h%h exp locked=1 3c", f_lk[0], f_dout[3], f_dout[4]); end
    cpu_cycle(1'b0, 1'b0, 4'h3, d, er, lk);
    cpu_cycle(1'b0, 1'b0, 4'h2, d, er, lk);
    cpu_cycle(1'b0, 1'b1, 4'h1, d, er, lk);
    cpu_cycle(1'b0, 1'b0, 4'h0, d, er, lk);
    checks++; if (d !== 4'hA) begin errors++; $display("[TB] FAIL pre_inject_m1 got=%h exp=a", d); end
    cpu_cycle(1'b1, 1'b0, 4'h0, d, er, lk);
    run_fetch(12'h123, 1'b1, 8);
    checks++; if (f_err[0] !== 1'b1 || f_lk[0] !== 1'b1) begin errors++; $display("[TB] FAIL sync_in_m2 err=%b locked=%b exp err=1 locked=1", f_err[0], f_lk[0]); end
    checks++; if (f_dout[3] !== 4'hA || f_dout[4] !== 4'h5) begin errors++; $display("[TB] FAIL realigned_fetch got=%h%h exp=a5", f_dout[3], f_dout[4]); end
  endtask

  task automatic test_reset_mid_fetch();
    logic [3:0] d;
    logic er, lk;
    logic [11:0] a;
    cpu_cycle(1'b0, 1'b0, 4'h3, d, er, lk);
    cpu_cycle(1'b0, 1'b0, 4'h2, d, er, lk);
    cpu_cycle(1'b0, 1'b1, 4'h1, d, er, lk);
    bus.host_req  = 1'b1;
    bus.host_we   = 1'b0;
    bus.host_addr = 12'h045;
    cpu_cycle(1'b0, 1'b0, 4'h0, d, er, lk);
    checks++; if (d !== 4'hA) begin errors++; $display("[TB] FAIL mid_fetch_m1 got=%h exp=a", d); end
    rst = 1'b1;
    bus.host_req = 1'b0;
    cpu_cycle(1'b0, 1'b0, 4'h0, d, er, lk);
    rst = 1'b0;
    checks++; if (d !== 4'h0 || lk !== 1'b0) begin errors++; $display("[TB] FAIL reset_mid_fetch dout=%h locked=%b exp 0/0", d, lk); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.host_ack !== 1'b0) begin errors++; $display("[TB] FAIL dropped_grant_ack cycle=%0d got=%b exp=0", i, bus.host_ack); end
      cpu_cycle(1'b0, 1'b0, 4'h0, d, er, lk);
    end
    cpu_cycle(1'b1, 1'b0, 4'h0, d, er, lk);
    for (int n = 0; n < 5; n++) begin
      a = (n == 0) ? 12'h123 : 12'($urandom_range(0, Depth - 1));
      run_fetch(a, 1'b1, 8);
      checks++; if ({f_dout[3], f_dout[4]} !== model[a[8:0]]) begin errors++; $display("[TB] FAIL ram_retained addr=%h got=%h%h exp=%h", a, f_dout[3], f_dout[4], model[a[8:0]]); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.sync       = 1'b0;
    bus.cm_rom     = 1'b0;
    bus.dbus_in    = 4'h0;
    bus.host_req   = 1'b0;
    bus.host_we    = 1'b0;
    bus.host_addr  = 12'h000;
    bus.host_wdata = 8'h00;
    test_reset();
    test_preload();
    test_lock();
    test_fetch_basic();
    test_cm_rom_off();
    test_hazard();
    test_random_traffic();
    test_out_of_range();
    test_sync_loss();
    test_reset_mid_fetch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
